// File: rtl/muldiv_unit.sv
// Shared multicycle multiply/divide engine with HI/LO result registers.
// Define MULDIV_UNSIGNED_EN to honour the Unsigned input (multu/divu).
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Op,
    input  logic             Unsigned,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero,
    output logic [WIDTH-1:0] HiOut,
    output logic [WIDTH-1:0] LoOut
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t state;
    state_t nextState;

    logic [CW-1:0]      cnt;
    logic               isMul;
    logic               negLo;
    logic               negHi;
    logic [WIDTH-1:0]   addend;
    logic [2*WIDTH-1:0] acc;

    logic               isUns;
    logic [WIDTH-1:0]   magA;
    logic [WIDTH-1:0]   magB;
    logic               accept;
    logic               byZero;
    logic               startRun;
    logic               lastIter;

`ifdef MULDIV_UNSIGNED_EN
    assign isUns = Unsigned;
`else
    logic unusedUnsigned;
    assign unusedUnsigned = Unsigned;
    assign isUns = 1'b0;
`endif

    assign magA = (A[WIDTH-1] && !isUns) ? -A : A;
    assign magB = (B[WIDTH-1] && !isUns) ? -B : B;

    assign accept   = (state == IDLE) && Start;
    assign byZero   = Op && (B == '0);
    assign startRun = accept && !byZero;
    assign lastIter = (cnt == CW'(WIDTH - 1));

    assign Busy = (state != IDLE);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:    if (startRun) nextState = RUN;
            RUN:     if (lastIter) nextState = FIX;
            FIX:     nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // One iteration: shift-add for multiply, restoring step for divide.
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     remShift;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] accStep;

    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        remShift = acc[2*WIDTH-1:WIDTH-1];
        diff     = remShift - {1'b0, addend};
        accStep  = acc;
        if (isMul) begin
            if (acc[0]) begin
                accStep = {sum, acc[WIDTH-1:1]};
            end else begin
                accStep = {1'b0, acc[2*WIDTH-1:1]};
            end
        end else if (!diff[WIDTH]) begin
            accStep = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            accStep = {remShift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
    end

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   hiNext;
    logic [WIDTH-1:0]   loNext;

    always_comb begin
        prod   = negLo ? -acc : acc;
        quo    = negLo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem    = negHi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        hiNext = isMul ? prod[2*WIDTH-1:WIDTH] : rem;
        loNext = isMul ? prod[WIDTH-1:0] : quo;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt     <= '0;
            isMul   <= 1'b0;
            negLo   <= 1'b0;
            negHi   <= 1'b0;
            addend  <= '0;
            acc     <= '0;
            Done    <= 1'b0;
            DivZero <= 1'b0;
            HiOut   <= '0;
            LoOut   <= '0;
        end else begin
            Done    <= 1'b0;
            DivZero <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept && byZero) begin
                        Done    <= 1'b1;
                        DivZero <= 1'b1;
                    end else if (accept) begin
                        cnt    <= '0;
                        isMul  <= !Op;
                        addend <= Op ? magB : magA;
                        acc    <= {{WIDTH{1'b0}}, (Op ? magA : magB)};
                        negLo  <= !isUns && (A[WIDTH-1] ^ B[WIDTH-1]);
                        negHi  <= !isUns && Op && A[WIDTH-1];
                    end
                end
                RUN: begin
                    acc <= accStep;
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    HiOut <= hiNext;
                    LoOut <= loNext;
                    Done  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed vector bench for muldiv_unit at WIDTH = 32.
// Expected values depend on whether MULDIV_UNSIGNED_EN is defined.
module tb_muldiv_unit;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic        Op;
    logic        Unsigned;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic        Done;
    logic        DivZero;
    logic [31:0] HiOut;
    logic [31:0] LoOut;

    muldiv_unit #(.WIDTH(32)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Start    (Start),
        .Op       (Op),
        .Unsigned (Unsigned),
        .A        (A),
        .B        (B),
        .Busy     (Busy),
        .Done     (Done),
        .DivZero  (DivZero),
        .HiOut    (HiOut),
        .LoOut    (LoOut)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int total;
    int bad;

    typedef struct {
        logic        op;
        logic        uns;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic runOp(input logic op, input logic uns,
                         input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic busySeen);
        Op = op;
        Unsigned = uns;
        A = a;
        B = b;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        Op = ~op;
        Unsigned = ~uns;
        A = 32'hA5A5A5A5;
        B = 32'h5A5A5A5A;
        lat = 1;
        busySeen = Busy;
        while (!Done && lat < 80) begin
            tick();
            lat++;
            busySeen |= Busy;
        end
    endtask

    int   lat;
    logic busySeen;
    logic doneSeen;
    string nm;

    initial begin
        total = 0;
        bad = 0;
        Reset = 1'b1;
        Start = 1'b0;
        Op = 1'b0;
        Unsigned = 1'b0;
        A = '0;
        B = '0;

        vecs[0] = '{1'b0, 1'b0, 32'd7, 32'hFFFFFFFD,
                    32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34};
        vecs[1] = '{1'b0, 1'b0, 32'h80000000, 32'h80000000,
                    32'h40000000, 32'h00000000, 1'b0, 34};
        vecs[2] = '{1'b1, 1'b0, 32'hFFFFFFF9, 32'd2,
                    32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34};
        vecs[3] = '{1'b1, 1'b0, 32'd5, 32'd2,
                    32'd1, 32'd2, 1'b0, 34};
        vecs[4] = '{1'b1, 1'b0, 32'd5, 32'd0,
                    32'd1, 32'd2, 1'b1, 1};
        vecs[5] = '{1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF,
                    32'd0, 32'h80000000, 1'b0, 34};
`ifdef MULDIV_UNSIGNED_EN
        vecs[6] = '{1'b0, 1'b1, 32'hFFFFFFFF, 32'd2,
                    32'h00000001, 32'hFFFFFFFE, 1'b0, 34};
`else
        vecs[6] = '{1'b0, 1'b1, 32'hFFFFFFFF, 32'd2,
                    32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 34};
`endif
        vecs[7] = '{1'b1, 1'b0, 32'd7, 32'hFFFFFFFE,
                    32'd1, 32'hFFFFFFFD, 1'b0, 34};
        vecs[8] = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF,
                    32'd0, 32'd1, 1'b0, 34};
        vecs[9] = '{1'b1, 1'b0, 32'd100, 32'd7,
                    32'd2, 32'd14, 1'b0, 34};

        tick();
        tick();
        check("reset_busy", 64'(Busy), 64'd0);
        check("reset_done", 64'(Done), 64'd0);
        check("reset_divzero", 64'(DivZero), 64'd0);
        check("reset_hi", 64'(HiOut), 64'd0);
        check("reset_lo", 64'(LoOut), 64'd0);
        Reset = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) begin
            runOp(vecs[i].op, vecs[i].uns, vecs[i].a, vecs[i].b,
                  lat, busySeen);
            nm = $sformatf("v%0d", i);
            check({nm, "_latency"}, 64'(lat), 64'(vecs[i].lat));
            check({nm, "_hi"}, 64'(HiOut), 64'(vecs[i].hi));
            check({nm, "_lo"}, 64'(LoOut), 64'(vecs[i].lo));
            check({nm, "_divzero"}, 64'(DivZero), 64'(vecs[i].dz));
            check({nm, "_busyseen"}, 64'(busySeen), 64'(!vecs[i].dz));
            check({nm, "_busy_at_done"}, 64'(Busy), 64'd0);
            tick();
            check({nm, "_done_pulse"}, 64'(Done), 64'd0);
            check({nm, "_dz_pulse"}, 64'(DivZero), 64'd0);
        end

        // Second Start while running is ignored.
        Op = 1'b0;
        Unsigned = 1'b0;
        A = 32'd3;
        B = 32'd4;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        lat = 1;
        repeat (4) begin
            tick();
            lat++;
        end
        Op = 1'b1;
        A = 32'd99;
        B = 32'd9;
        Start = 1'b1;
        tick();
        lat++;
        Start = 1'b0;
        while (!Done && lat < 80) begin
            tick();
            lat++;
        end
        check("hs_latency", 64'(lat), 64'd34);
        check("hs_lo", 64'(LoOut), 64'd12);
        check("hs_hi", 64'(HiOut), 64'd0);
        tick();
        check("hs_no_requeue", 64'(Busy), 64'd0);

        // Reset in cycle 10 aborts and clears HI/LO.
        Op = 1'b0;
        A = 32'd5;
        B = 32'd6;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        repeat (9) tick();
        check("rst_busy_before", 64'(Busy), 64'd1);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("rst_busy_after", 64'(Busy), 64'd0);
        check("rst_hi", 64'(HiOut), 64'd0);
        check("rst_lo", 64'(LoOut), 64'd0);
        doneSeen = 1'b0;
        repeat (40) begin
            tick();
            doneSeen |= Done;
        end
        check("rst_no_done", 64'(doneSeen), 64'd0);

        // Reset and Start together: the operation is not accepted.
        A = 32'd3;
        B = 32'd3;
        Reset = 1'b1;
        Start = 1'b1;
        tick();
        Reset = 1'b0;
        Start = 1'b0;
        check("rst_start_busy", 64'(Busy), 64'd0);
        doneSeen = 1'b0;
        repeat (40) begin
            tick();
            doneSeen |= Done;
        end
        check("rst_start_no_done", 64'(doneSeen), 64'd0);
        check("rst_start_lo", 64'(LoOut), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised multicycle multiply/divide unit for the MIPS multicycle datapath. It replaces the separate fixed-width Mult and Div blocks and the two HI/LO source muxes with one shared sequential engine. The engine has a start/done handshake and its own HI/LO result registers. The control unit pulses Start for mult/div instructions, stalls on Busy, and reads HiOut/LoOut for mfhi/mflo.

## Interface
Parameters:
- WIDTH, 32, operand width; results are WIDTH each on HI and LO; must be ≥ 4.

Ports:
- Clk  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high reset
- Start  in  1  request a new operation; sampled only in IDLE
- Op  in  1  0 = multiply, 1 = divide
- Unsigned  in  1  1 = unsigned operation (honoured only with MULDIV_UNSIGNED_EN)
- A  in  WIDTH  multiplicand / dividend, captured on the accepting edge
- B  in  WIDTH  multiplier / divisor, captured on the accepting edge
- Busy  out  1  high in RUN and FIX
- Done  out  1  one-cycle completion pulse
- DivZero  out  1  high with Done when a divide had B = 0
- HiOut  out  WIDTH  HI register: product upper half, or remainder
- LoOut  out  WIDTH  LO register: product lower half, or quotient

## Operation
- FSM states: IDLE, RUN, FIX.
- IDLE → RUN on Start.
  - Latch the operand magnitudes, the result sign and the remainder sign (dividend sign).
  - Clear the iteration counter (ceil(log2 WIDTH) bits).
- IDLE with Start, Op = 1, B = 0: stay in IDLE. Assert Done and DivZero the next cycle. HI and LO are unchanged.
- RUN multiply: radix-2 shift-add on the magnitudes, one bit per cycle, into a 2·WIDTH accumulator.
- RUN divide: restoring shift-subtract, one quotient bit per cycle.
- RUN → FIX when the counter reaches WIDTH−1, i.e. after exactly WIDTH iterations.
- FIX → IDLE:
  - Apply the two's-complement sign correction.
  - Write HI and LO.
  - Pulse Done.
- Signed multiply: HI:LO = exact 2·WIDTH-bit product.
- Signed divide, MIPS semantics:
  - LO = quotient truncated toward zero.
  - HI = remainder carrying the dividend's sign.
  - Most-negative ÷ −1: LO = most-negative (wraps), HI = 0. No flag.
- Start outside IDLE is ignored; there is no queueing. A, B, Op and Unsigned are don't-care after the accepting edge.
- HI and LO hold their value until the next successful completion.

## Timing
- Reset values: FSM = IDLE, counter = 0, Busy = 0, Done = 0, DivZero = 0, HiOut = 0, LoOut = 0.
- Cycle numbering: Start is sampled at the edge ending cycle 0.
  - Cycles 1..WIDTH: RUN, Busy = 1.
  - Cycle WIDTH+1: FIX, Busy = 1.
  - Cycle WIDTH+2: Done = 1, HiOut/LoOut carry the new result, Busy = 0. A new Start is accepted this cycle.
- Total latency: WIDTH+2 cycles from the Start cycle to Done. For WIDTH = 32 that is 34.
- Divide by zero: Done = DivZero = 1 in cycle 1 and Busy never rises.
- Done and DivZero are registered, high for exactly one cycle.
- Reset mid-operation:
  - Aborts to IDLE on the next edge.
  - No Done is produced.
  - HI and LO are cleared.
- Reset and Start in the same cycle: Reset wins and the operation is not accepted.

## Configuration
- MULDIV_UNSIGNED_EN defined:
  - Unsigned = 1 skips the magnitude/sign logic and implements multu/divu.
  - Unsigned divide by zero still gives DivZero.
- Not defined: the Unsigned port is ignored and every operation is signed. The sign-bypass logic is not synthesised.

## Test plan
All scenarios use WIDTH = 32.
- Signed mult: A = 7, B = −3 (0xFFFFFFFD) → Done in cycle 34, HI = 0xFFFFFFFF, LO = 0xFFFFFFEB, DivZero = 0.
- Signed mult, extremes: A = B = 0x80000000 → HI = 0x40000000, LO = 0x00000000.
- Signed div: A = −7, B = 2 → LO = 0xFFFFFFFD (−3), HI = 0xFFFFFFFF (−1).
- Divide after the previous result (HI = 1, LO = 2):
  - A = 5, B = 0 → Done and DivZero in cycle 1, Busy stays 0, HI = 1 and LO = 2 unchanged.
  - Then 0x80000000 ÷ −1 → LO = 0x80000000, HI = 0.
- Unsigned mult: A = 0xFFFFFFFF, B = 2, Unsigned = 1.
  - With MULDIV_UNSIGNED_EN: HI = 0x00000001, LO = 0xFFFFFFFE.
  - Without it: HI = 0xFFFFFFFF, LO = 0xFFFFFFFE.
- Handshake and reset:
  - Start mult 3×4; pulse Start again in cycle 5 with different operands → ignored, Done in cycle 34 with LO = 12.
  - Start another op, assert Reset in cycle 10 → Busy = 0 in cycle 11, no Done, HI = LO = 0.
